// File: rtl/lab2_proc_muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package lab2_proc_MulDivPkg;

  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } muldiv_fn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/lab2_proc_muldiv_unit_dpath.sv
// Datapath: shift-add multiply / restoring divide registers, 33-bit trial
// subtract, and the signed fix-up applied as the result is latched.
module lab2_proc_MulDivDpath
  import lab2_proc_MulDivPkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_last,
  input  logic             i_early,
  input  logic [NBITS-1:0] i_early_val,
  input  logic [2:0]       i_fn,
  input  logic [NBITS-1:0] i_a,
  input  logic [NBITS-1:0] i_b,
  output logic [NBITS-1:0] o_res
);

  logic [2*NBITS-1:0] r_acc, r_a;
  logic [NBITS-1:0]   r_b, r_res;
  logic               r_mul, r_rem_op, r_neg_q, r_neg_r;

  logic               w_mul, w_sgn, w_rem;
  logic [NBITS-1:0]   w_abs_a, w_abs_b;
  logic [2*NBITS-1:0] w_sh, w_acc_nxt;
  logic [NBITS:0]     w_diff;
  logic               w_ge;
  logic [NBITS-1:0]   w_quo, w_rem_v, w_res_nxt;

  assign w_mul   = (i_fn == MD_MUL);
  assign w_sgn   = (i_fn == MD_DIV) || (i_fn == MD_REM);
  assign w_rem   = (i_fn == MD_REM) || (i_fn == MD_REMU);
  assign w_abs_a = (w_sgn && i_a[NBITS-1]) ? -i_a : i_a;
  assign w_abs_b = (w_sgn && i_b[NBITS-1]) ? -i_b : i_b;

  // r_acc holds {rem,quo} for divide; the bit shifted out of rem is kept as
  // the 33rd bit of the trial subtract, whose sign bit means "rem < divisor".
  assign w_sh   = r_acc << 1;
  assign w_diff = {r_acc[2*NBITS-1], w_sh[2*NBITS-1:NBITS]} - {1'b0, r_b};
  assign w_ge   = !w_diff[NBITS];

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mul) begin
      if (r_b[0]) w_acc_nxt = r_acc + r_a;
    end else begin
      w_acc_nxt = {(w_ge ? w_diff[NBITS-1:0] : w_sh[2*NBITS-1:NBITS]),
                   w_sh[NBITS-1:1], w_ge};
    end
  end

  assign w_quo   = w_acc_nxt[NBITS-1:0];
  assign w_rem_v = w_acc_nxt[2*NBITS-1:NBITS];

  always_comb begin
    w_res_nxt = w_quo;
    if (!r_mul) begin
      if (r_rem_op) w_res_nxt = r_neg_r ? -w_rem_v : w_rem_v;
      else          w_res_nxt = r_neg_q ? -w_quo   : w_quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_mul    <= 1'b0;
      r_rem_op <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      if (i_load) begin
        r_acc    <= w_mul ? '0 : {{NBITS{1'b0}}, w_abs_a};
        r_a      <= {{NBITS{1'b0}}, i_a};
        r_b      <= w_mul ? i_b : w_abs_b;
        r_mul    <= w_mul;
        r_rem_op <= w_rem;
        r_neg_q  <= w_sgn && (i_a[NBITS-1] ^ i_b[NBITS-1]);
        r_neg_r  <= w_sgn && i_a[NBITS-1];
      end else if (i_step) begin
        r_acc <= w_acc_nxt;
        if (r_mul) begin
          r_a <= r_a << 1;
          r_b <= r_b >> 1;
        end
      end
      if (i_early)     r_res <= i_early_val;
      else if (i_last) r_res <= w_res_nxt;
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/lab2_proc_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and
// early-out detection around the shared datapath.
module lab2_proc_muldiv_unit
  import lab2_proc_MulDivPkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_data
);

  localparam int CW = $clog2(NBITS);

  muldiv_state_t    r_state, w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             w_fire, w_last;
  logic             w_illegal, w_divlike, w_b_zero, w_ovf, w_early;
  logic [NBITS-1:0] w_early_val;

  assign req_rdy  = (r_state == IDLE);
  assign resp_val = (r_state == DONE);
  assign w_fire   = req_val && req_rdy;
  assign w_last   = (r_state == CALC) && (r_count == CW'(NBITS-1));

  assign w_illegal = (req_fn > 3'd4);
  assign w_divlike = !w_illegal && (req_fn != MD_MUL);
  assign w_b_zero  = (req_b == '0);
  assign w_ovf     = ((req_fn == MD_DIV) || (req_fn == MD_REM)) &&
                     (req_a == INT_MIN) && (req_b == '1);
  assign w_early   = w_illegal || (w_divlike && w_b_zero) || w_ovf;

  // Divide-by-zero takes priority over the INT_MIN/-1 overflow case.
  always_comb begin
    w_early_val = '0;
    if (!w_illegal) begin
      if (w_b_zero)
        w_early_val = ((req_fn == MD_DIV) || (req_fn == MD_DIVU)) ? DIV_BY_ZERO_Q : req_a;
      else if (w_ovf)
        w_early_val = (req_fn == MD_DIV) ? INT_MIN : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_fire) w_state_nxt = w_early ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (resp_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire)                 r_count <= '0;
      else if (r_state == CALC)   r_count <= r_count + 1'b1;
    end
  end

  lab2_proc_MulDivDpath #(.NBITS(NBITS)) u_dpath (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_fire && !w_early),
    .i_step      (r_state == CALC),
    .i_last      (w_last),
    .i_early     (w_fire && w_early),
    .i_early_val (w_early_val),
    .i_fn        (req_fn),
    .i_a         (req_a),
    .i_b         (req_b),
    .o_res       (resp_data)
  );

endmodule
